integer_mac_posr: RTL

INTEGER_MAC_POSR -- requirements
Module: integer_mac_posr

---
 rtl/int_arith_pkg.sv | 21 ++
 rtl/mag_sign_split.sv | 18 +
 rtl/integer_mac_posr.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/int_arith_pkg.sv
// Shared definitions for the integer multiply-accumulate block:
// default datapath width, FSM state type and counter width helper.
package int_arith_pkg;

    localparam int unsigned DEFAULT_N = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    // Down-counter must hold N/2 itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n / 2) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEFAULT_N);

endpackage

// File: rtl/mag_sign_split.sv
// Two's complement to unsigned magnitude plus sign.
// The most negative value maps to magnitude 2^(W-1), which still fits in W
// bits when the magnitude is read as unsigned.
module mag_sign_split #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] mag,
    output logic         sign
);

    // Negate negative inputs; the unsigned view absorbs the -2^(W-1) case.
    always_comb begin
        sign = a[W-1];
        mag  = sign ? -a : a;
    end

endmodule

// File: rtl/integer_mac_posr.sv
// Sequential reconstruction of a dividend x = q*y + r from a signed
// quotient, divisor and remainder, using an LSB-first shift-add multiplier.
// Optional feature: define INTEGER_MAC_REMCHECK_EN to flag operand triples
// that are not a valid positive-remainder division (y == 0, r < 0, r >= |y|).
module integer_mac_posr
    import int_arith_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N/2-1:0] q,
    input  logic [N/2-1:0] y,
    input  logic [N/2-1:0] r,
    output logic [N-1:0]   x,
    output logic           err,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int unsigned H  = N / 2;
    localparam int unsigned CW = cnt_width(N);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [N-1:0]   acc_q,   acc_d;
    logic [H-1:0]   qmag_q,  qmag_d;
    logic [N-1:0]   ysh_q,   ysh_d;
    logic           neg_q,   neg_d;
    logic [H-1:0]   r_q,     r_d;
    logic [N-1:0]   x_q,     x_d;
    logic           err_q,   err_d;

    logic [H-1:0]   q_mag, y_mag;
    logic           q_sign, y_sign;

    logic [N-1:0]   acc_fix;
    logic [N-1:0]   r_ext;
    logic [N-1:0]   sum;
    logic           err_chk;

    mag_sign_split #(.W(H)) u_split_q (
        .a    (q),
        .mag  (q_mag),
        .sign (q_sign)
    );

    mag_sign_split #(.W(H)) u_split_y (
        .a    (y),
        .mag  (y_mag),
        .sign (y_sign)
    );

    // Final correction: apply product sign, then add sign-extended remainder.
    always_comb begin
        acc_fix = neg_q ? -acc_q : acc_q;
        r_ext   = {{H{r_q[H-1]}}, r_q};
        sum     = acc_fix + r_ext;
    end

`ifdef INTEGER_MAC_REMCHECK_EN
    logic [H-1:0] ymag_q, ymag_d;

    // Remainder validity: divisor nonzero, remainder in [0, |y|).
    always_comb begin
        err_chk = (ymag_q == '0) || r_q[H-1] || (r_q >= ymag_q);
    end
`else
    // Check disabled: error flag is constant zero.
    always_comb begin
        err_chk = 1'b0;
    end
`endif

    // Next-state and datapath update for the IDLE/RUN/FIX/DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        qmag_d  = qmag_q;
        ysh_d   = ysh_q;
        neg_d   = neg_q;
        r_d     = r_q;
        x_d     = x_q;
        err_d   = err_q;
`ifdef INTEGER_MAC_REMCHECK_EN
        ymag_d  = ymag_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    qmag_d  = q_mag;
                    ysh_d   = {{H{1'b0}}, y_mag};
                    neg_d   = q_sign ^ y_sign;
                    r_d     = r;
                    acc_d   = '0;
                    cnt_d   = CW'(H);
                    state_d = RUN;
`ifdef INTEGER_MAC_REMCHECK_EN
                    ymag_d  = y_mag;
`endif
                end
            end
            RUN: begin
                if (qmag_q[0]) begin
                    acc_d = acc_q + ysh_q;
                end
                qmag_d = qmag_q >> 1;
                ysh_d  = ysh_q << 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                x_d     = sum;
                err_d   = err_chk;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            qmag_q  <= '0;
            ysh_q   <= '0;
            neg_q   <= 1'b0;
            r_q     <= '0;
            x_q     <= '0;
            err_q   <= 1'b0;
`ifdef INTEGER_MAC_REMCHECK_EN
            ymag_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            qmag_q  <= qmag_d;
            ysh_q   <= ysh_d;
            neg_q   <= neg_d;
            r_q     <= r_d;
            x_q     <= x_d;
            err_q   <= err_d;
`ifdef INTEGER_MAC_REMCHECK_EN
            ymag_q  <= ymag_d;
`endif
        end
    end

    // Handshake flags decode directly from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        x         = x_q;
        err       = err_q;
    end

endmodule
